// File: rtl/regfile_chain_sequencer_pkg.sv
// Shared constants and FSM state type for the register-file chain sequencer.
package regfile_chain_sequencer_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned RF_DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACC,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/regfile_chain_sequencer_chain_mul_step.sv
// One multiply step of the chain: 8x8 product, low byte plus a flag that the
// high byte was nonzero.
module chain_mul_step
  import regfile_chain_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] prod_lo,
  output logic              ovf
);

  logic [2*DATA_W-1:0] full;

  // Full-width product split into kept low byte and overflow indication.
  always_comb begin
    full    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    prod_lo = full[DATA_W-1:0];
    ovf     = |full[2*DATA_W-1:DATA_W];
  end

endmodule

// File: rtl/regfile_chain_sequencer.sv
// Master-side sequencer: reads COUNT registers from BASE two per access,
// folds them into an 8-bit running product and writes it back to DST.
module regfile_chain_sequencer
  import regfile_chain_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_sel_i,
  output logic [ADDR_W-1:0] rf_sel_j,
  input  logic [DATA_W-1:0] rf_rdata_i,
  input  logic [DATA_W-1:0] rf_rdata_j
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              err_q, err_d;

  logic              cmd_legal;
  logic              two_ops;
  logic [DATA_W-1:0] p1_lo, p2_lo;
  logic              p1_ovf, p2_ovf;

  chain_mul_step u_step_i (
    .a       (acc_q),
    .b       (rf_rdata_i),
    .prod_lo (p1_lo),
    .ovf     (p1_ovf)
  );

  chain_mul_step u_step_j (
    .a       (p1_lo),
    .b       (rf_rdata_j),
    .prod_lo (p2_lo),
    .ovf     (p2_ovf)
  );

  // Command legality and whether this access carries two operands.
  always_comb begin
    cmd_legal = (count != '0) && (count <= CNT_W'(RF_DEPTH));
    two_ops   = (rem_q >= CNT_W'(2));
  end

  // Datapath next-state: command latch, accumulate step, result capture.
  always_comb begin
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    dst_d      = dst_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cmd_legal) begin
            ptr_d = base_addr;
            rem_d = count;
            dst_d = dst_addr;
            acc_d = DATA_W'(1);
            ovf_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ACC: begin
        // With a single operand left the J read is discarded entirely,
        // including its overflow contribution.
        acc_d = two_ops ? p2_lo : p1_lo;
        ovf_d = ovf_q | p1_ovf | (two_ops & p2_ovf);
        ptr_d = ptr_q + ADDR_W'(2);
        rem_d = two_ops ? (rem_q - CNT_W'(2)) : '0;
      end
      ST_WRITE: begin
        // Captured here so result/overflow are already valid in the DONE cycle.
        result_d   = acc_q;
        overflow_d = ovf_q;
      end
      default: ;
    endcase
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && cmd_legal) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ACC;
      ST_ACC:   state_d = (rem_d != '0) ? ST_ISSUE : ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      dst_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      dst_q      <= dst_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy     = (state_q == ST_ISSUE) || (state_q == ST_ACC) || (state_q == ST_WRITE);
    done     = (state_q == ST_DONE);
    err      = err_q;
    result   = result_q;
    overflow = overflow_q;
    rf_we    = (state_q == ST_WRITE);
    rf_waddr = '0;
    rf_wdata = '0;
    rf_sel_i = '0;
    rf_sel_j = '0;
    if (state_q == ST_ISSUE) begin
      rf_sel_i = ptr_q;
      rf_sel_j = ptr_q + ADDR_W'(1);
    end
    if (state_q == ST_WRITE) begin
      rf_waddr = dst_q;
      rf_wdata = acc_q;
    end
  end

endmodule
